// File: rtl/uart_pkg.sv
// Shared types and character constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORD = 2'd1,
    BYTE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT = 8'h30;
  // 'A' - 10, so nibble 0xA lands on 'A'
  localparam logic [7:0] ASCII_ALPHA = 8'h37;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase hex ASCII character.
module hex_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nib < 4'hA) o_ascii = ASCII_DIGIT + {4'h0, i_nib};
    else              o_ascii = ASCII_ALPHA + {4'h0, i_nib};
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates word-print and raw-byte requests and streams the resulting
// characters to a ready/valid UART byte transmitter.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CRLF = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wreq,
  input  logic [31:0] wdata,
  output logic        wack,
  input  logic        breq,
  input  logic [7:0]  bdata,
  output logic        back,
  output logic        tx_vld,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = (CRLF != 0) ? 4'd9 : 4'd7;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic        r_last_byte, w_last_byte_nxt;
  logic        r_tx_vld, w_tx_vld_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic        r_wack, w_wack_nxt;
  logic        r_back, w_back_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_xfer;
  logic [3:0]  w_idx_inc;
  logic [3:0]  w_nib;
  logic [7:0]  w_ascii;
  logic [7:0]  w_char_nxt;

  assign w_xfer    = r_tx_vld & tx_rdy;
  assign w_idx_inc = r_idx + 4'd1;

  // In IDLE the first nibble comes straight from wdata so it can be
  // presented in the grant cycle; afterwards it is picked from the
  // captured word, MSB nibble first.
  always_comb begin
    if (r_state == IDLE) w_nib = wdata[31:28];
    else                 w_nib = r_word[{~w_idx_inc[2:0], 2'b00} +: 4];
  end

  hex_to_ascii u_hex (
    .i_nib   (w_nib),
    .o_ascii (w_ascii)
  );

  always_comb begin
    if      (w_idx_inc == 4'd8) w_char_nxt = ASCII_CR;
    else if (w_idx_inc == 4'd9) w_char_nxt = ASCII_LF;
    else                        w_char_nxt = w_ascii;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_word_nxt      = r_word;
    w_byte_nxt      = r_byte;
    w_last_byte_nxt = r_last_byte;
    w_tx_vld_nxt    = r_tx_vld;
    w_tx_data_nxt   = r_tx_data;
    w_wack_nxt      = 1'b0;
    w_back_nxt      = 1'b0;
    w_busy_nxt      = r_busy;
    case (r_state)
      IDLE: begin
        // On a tie the side not served last wins
        if (wreq && (!breq || r_last_byte)) begin
          w_state_nxt     = WORD;
          w_word_nxt      = wdata;
          w_idx_nxt       = 4'd0;
          w_last_byte_nxt = 1'b0;
          w_wack_nxt      = 1'b1;
          w_tx_vld_nxt    = 1'b1;
          w_tx_data_nxt   = w_ascii;
          w_busy_nxt      = 1'b1;
        end else if (breq) begin
          w_state_nxt     = BYTE;
          w_byte_nxt      = bdata;
          w_idx_nxt       = 4'd0;
          w_last_byte_nxt = 1'b1;
          w_back_nxt      = 1'b1;
          w_tx_vld_nxt    = 1'b1;
          w_tx_data_nxt   = bdata;
          w_busy_nxt      = 1'b1;
        end
      end
      WORD: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt  = IDLE;
            w_tx_vld_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_tx_data_nxt = w_char_nxt;
          end
        end
      end
      BYTE: begin
        w_tx_data_nxt = r_byte;
        if (w_xfer) begin
          w_state_nxt  = IDLE;
          w_tx_vld_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_tx_vld_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_word      <= 32'h0;
      r_byte      <= 8'h0;
      r_last_byte <= 1'b1;
      r_tx_vld    <= 1'b0;
      r_tx_data   <= 8'h0;
      r_wack      <= 1'b0;
      r_back      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_word      <= w_word_nxt;
      r_byte      <= w_byte_nxt;
      r_last_byte <= w_last_byte_nxt;
      r_tx_vld    <= w_tx_vld_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_wack      <= w_wack_nxt;
      r_back      <= w_back_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign wack    = r_wack;
  assign back    = r_back;
  assign tx_vld  = r_tx_vld;
  assign tx_data = r_tx_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based character model plus directed scenarios.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wreq, breq, tx_rdy;
  logic [31:0] wdata;
  logic [7:0]  bdata;
  logic        wack, back, tx_vld, busy;
  logic [7:0]  tx_data;

  logic        w2req, b2req, tx2_rdy;
  logic [31:0] w2data;
  logic [7:0]  b2data;
  logic        w2ack, b2ack, tx2_vld, busy2;
  logic [7:0]  tx2_data;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] expq[$];
  logic [7:0] log0[$];
  logic [7:0] log2[$];
  int         grants[$];
  int         vld_cycles;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h0;

  always #5 clk = ~clk;

  uart_tx_sched #(.CRLF(1)) u0 (
    .clk(clk), .rstn(rstn), .wreq(wreq), .wdata(wdata), .wack(wack),
    .breq(breq), .bdata(bdata), .back(back), .tx_vld(tx_vld),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .busy(busy)
  );

  uart_tx_sched #(.CRLF(0)) u1 (
    .clk(clk), .rstn(rstn), .wreq(w2req), .wdata(w2data), .wack(w2ack),
    .breq(b2req), .bdata(b2data), .back(b2ack), .tx_vld(tx2_vld),
    .tx_data(tx2_data), .tx_rdy(tx2_rdy), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] hexchar(input int v);
    if (v < 10) return 8'(48 + v);   // '0'..'9'
    return 8'(65 + v - 10);          // 'A'..'F'
  endfunction

  task automatic push_word(input logic [31:0] w, input bit crlf);
    for (int i = 7; i >= 0; i--) expq.push_back(hexchar(int'((w >> (4 * i)) & 32'hF)));
    if (crlf) begin
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || expq.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_tx_vld", 32'(tx_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    expq.delete();
    tick(1);
    rstn = 1'b1;
  endtask

  // Compare process: every byte handed over must be the model's next byte,
  // and a stalled byte must not change.
  always @(negedge clk) begin
    if (rstn) begin
      if (hold_prev) begin
        chk("stall_vld", 32'(tx_vld), 32'd1);
        chk("stall_data", 32'(tx_data), 32'(hold_data));
      end
      if (tx_vld) vld_cycles++;
      if (wack) grants.push_back(1);
      if (back) grants.push_back(2);
      if (tx_vld && tx_rdy) begin
        log0.push_back(tx_data);
        if (expq.size() == 0) begin
          n_total++;
          $display("FAIL tx_byte_unexpected: got %0h expected none", tx_data);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(expq.pop_front()));
        end
      end
      hold_prev = tx_vld && !tx_rdy;
      hold_data = tx_data;
      if (tx2_vld && tx2_rdy) log2.push_back(tx2_data);
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    logic [7:0] lit1[10];
    logic [7:0] lit5[10];
    int acks;
    int n;
    lit1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    lit5 = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
    wreq = 0; breq = 0; wdata = 0; bdata = 0; tx_rdy = 1;
    w2req = 0; b2req = 0; w2data = 0; b2data = 0; tx2_rdy = 1;
    rstn = 1'b0;
    #3;
    chk("rst_tx_vld0", 32'(tx_vld), 32'd0);
    chk("rst_tx_data0", 32'(tx_data), 32'h0);
    chk("rst_wack0", 32'(wack), 32'd0);
    chk("rst_back0", 32'(back), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(1);

    // Word 0x1234ABCD back to back
    log0.delete();
    wdata = 32'h1234ABCD; wreq = 1;
    push_word(wdata, 1);
    tick(1);
    vld_cycles = 0;
    chk("w1_wack", 32'(wack), 32'd1);
    chk("w1_first", 32'(tx_data), 32'h31);
    wreq = 0;
    tick(1);
    chk("w1_wack_pulse", 32'(wack), 32'd0);
    wait_idle();
    chk("w1_vld_cycles", 32'(vld_cycles), 32'd10);
    chk("w1_busy_after", 32'(busy), 32'd0);
    chk("w1_len", 32'(log0.size()), 32'd10);
    for (int i = 0; i < 10 && i < log0.size(); i++) chk("w1_lit", 32'(log0[i]), 32'(lit1[i]));

    // Byte 0x55 under 5 cycles of backpressure
    log0.delete();
    bdata = 8'h55; breq = 1;
    expq.push_back(8'h55);
    tick(1);
    vld_cycles = 0;
    tx_rdy = 0;
    chk("b1_back", 32'(back), 32'd1);
    breq = 0;
    tick(1);
    chk("b1_back_pulse", 32'(back), 32'd0);
    tick(4);
    tx_rdy = 1;
    wait_idle();
    chk("b1_vld_cycles", 32'(vld_cycles), 32'd6);
    chk("b1_transfers", 32'(log0.size()), 32'd1);

    // Round robin with both requests held
    do_reset();
    grants.delete();
    wdata = 32'h0000BEEF; bdata = 8'hA5;
    push_word(wdata, 1);
    expq.push_back(8'hA5);
    push_word(wdata, 1);
    wreq = 1; breq = 1;
    acks = 0; n = 0;
    while (acks < 3 && n < 200) begin
      tick(1);
      n++;
      if (wack || back) acks++;
    end
    wreq = 0; breq = 0;
    chk("rr_timeout", 32'(n < 200), 32'd1);
    wait_idle();
    chk("rr_ngrants", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      chk("rr_g0_word", 32'(grants[0]), 32'd1);
      chk("rr_g1_byte", 32'(grants[1]), 32'd2);
      chk("rr_g2_word", 32'(grants[2]), 32'd1);
    end

    // Byte request raised mid-word is served only after the idle cycle
    wdata = 32'hCAFE0001; wreq = 1;
    push_word(wdata, 1);
    tick(1);
    chk("mid_wack", 32'(wack), 32'd1);
    wreq = 0;
    tick(2);
    bdata = 8'h3C; breq = 1;
    expq.push_back(8'h3C);
    n = 0;
    while (busy && n < 200) begin
      chk("mid_no_back", 32'(back), 32'd0);
      tick(1);
      n++;
    end
    chk("mid_idle_vld", 32'(tx_vld), 32'd0);
    tick(1);
    chk("mid_back", 32'(back), 32'd1);
    chk("mid_byte", 32'(tx_data), 32'h3C);
    breq = 0;
    wait_idle();

    // Reset after three bytes of a word, then a fresh word
    log0.delete();
    wdata = 32'hDEADBEEF; wreq = 1;
    push_word(wdata, 1);
    tick(1);
    wreq = 0;
    tick(3);
    chk("ab_sent", 32'(log0.size()), 32'd3);
    do_reset();
    tick(2);
    chk("ab_no_resume", 32'(tx_vld), 32'd0);
    log0.delete();
    wdata = 32'h00000009; wreq = 1;
    push_word(wdata, 1);
    tick(1);
    wreq = 0;
    wait_idle();
    chk("ab_len", 32'(log0.size()), 32'd10);
    for (int i = 0; i < 10 && i < log0.size(); i++) chk("ab_lit", 32'(log0[i]), 32'(lit5[i]));

    // CRLF=0 instance: eight 'F' characters only
    log2.delete();
    w2data = 32'hFFFFFFFF; w2req = 1;
    tick(1);
    chk("nocrlf_wack", 32'(w2ack), 32'd1);
    w2req = 0;
    n = 0;
    while (busy2 && n < 200) begin
      tick(1);
      n++;
    end
    chk("nocrlf_timeout", 32'(n < 200), 32'd1);
    tick(2);
    chk("nocrlf_len", 32'(log2.size()), 32'd8);
    for (int i = 0; i < log2.size(); i++) chk("nocrlf_byte", 32'(log2[i]), 32'h46);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
